// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage register: opcode/funct encodings,
// stage-mode selection and the T_new values produced by the decode stage.
package pipe_pkg;

  localparam int MODE_DECODE     = 0;
  localparam int MODE_DOWNSTREAM = 1;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011;

  localparam logic [5:0] FN_ADDU    = 6'b100001;
  localparam logic [5:0] FN_SUBU    = 6'b100011;

  localparam int TNEW_JAL  = 0;
  localparam int TNEW_ALU  = 1;
  localparam int TNEW_LOAD = 2;

  localparam int REG_RA    = 31;

endpackage

// File: rtl/pipe_stage_reg_tnew_decode.sv
// Combinational decode-stage classifier: derives T_new, destination register
// and register-write flag from a raw instruction word.
module tnew_decode
  import pipe_pkg::*;
#(
  parameter int RW = 5,
  parameter int TW = 2
) (
  input  logic [31:0]   instr,
  output logic [TW-1:0] tnew,
  output logic [RW-1:0] dest,
  output logic          wen
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       unused_bits;

  assign opcode      = instr[31:26];
  assign funct       = instr[5:0];
  assign rt          = instr[20:16];
  assign rd          = instr[15:11];
  assign unused_bits = ^{instr[25:21], instr[10:6]};

  // NOTE: every output gets a default first so no path through the case leaves
  // a value unassigned -- that is what keeps always_comb from inferring a latch.
  always_comb begin
    tnew = '0;
    dest = '0;
    wen  = 1'b0;
    case (opcode)
      OP_ORI, OP_LUI: begin
        tnew = TW'(TNEW_ALU);
        dest = RW'(rt);
        wen  = 1'b1;
      end
      OP_LW: begin
        tnew = TW'(TNEW_LOAD);
        dest = RW'(rt);
        wen  = 1'b1;
      end
      OP_JAL: begin
        tnew = TW'(TNEW_JAL);
        dest = RW'(REG_RA);
        wen  = 1'b1;
      end
      OP_SPECIAL: begin
        if (funct == FN_ADDU || funct == FN_SUBU) begin
          tnew = TW'(TNEW_ALU);
          dest = RW'(rd);
          wen  = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with stall/flush and hazard bookkeeping (T_new,
// destination, write flag); MODE selects decode-stage or downstream behaviour.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RW   = 5,
  parameter int TW   = 2,
  parameter int MODE = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            flush,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] rd1_in,
  input  logic [XLEN-1:0] rd2_in,
  input  logic [XLEN-1:0] ext_in,
  input  logic [RW-1:0]   a1_in,
  input  logic [RW-1:0]   a2_in,
  input  logic [RW-1:0]   a3_in,
  input  logic [TW-1:0]   tnew_in,
  input  logic            wen_in,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc8,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic [XLEN-1:0] ext,
  output logic [RW-1:0]   a1,
  output logic [RW-1:0]   a2,
  output logic [RW-1:0]   a3,
  output logic [TW-1:0]   tnew,
  output logic            wen,
  output logic            valid
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(8);

  logic [TW-1:0] nxt_tnew;
  logic [RW-1:0] nxt_dest;
  logic          nxt_wen_raw;
  logic          nxt_wen;

  if (MODE == MODE_DECODE) begin : g_decode
    logic unused_in;
    assign unused_in = ^{tnew_in, a3_in, wen_in};

    tnew_decode #(.RW(RW), .TW(TW)) u_tnew_decode (
      .instr (instr_in[31:0]),
      .tnew  (nxt_tnew),
      .dest  (nxt_dest),
      .wen   (nxt_wen_raw)
    );
  end else begin : g_downstream
    // One cycle has elapsed since the previous stage, so T_new counts down,
    // but it must stick at zero rather than wrap to all-ones.
    assign nxt_tnew    = (tnew_in == '0) ? '0 : tnew_in - TW'(1);
    assign nxt_dest    = a3_in;
    assign nxt_wen_raw = wen_in;
  end

  // Register $0 is hard-wired, so a write aimed at it is not a real write.
  assign nxt_wen = nxt_wen_raw && (nxt_dest != '0);

  // NOTE: declaration initialisers give the bubble state at power-up, before
  // any reset arrives; they are not a substitute for the synchronous reset.
  logic [XLEN-1:0] instr_q = '0;
  logic [XLEN-1:0] pc_q    = '0;
  logic [XLEN-1:0] pc8_q   = PC_STEP;
  logic [XLEN-1:0] rd1_q   = '0;
  logic [XLEN-1:0] rd2_q   = '0;
  logic [XLEN-1:0] ext_q   = '0;
  logic [RW-1:0]   a1_q    = '0;
  logic [RW-1:0]   a2_q    = '0;
  logic [RW-1:0]   a3_q    = '0;
  logic [TW-1:0]   tnew_q  = '0;
  logic            wen_q   = 1'b0;
  logic            valid_q = 1'b0;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      instr_q <= '0;
      pc_q    <= '0;
      pc8_q   <= PC_STEP;
      rd1_q   <= '0;
      rd2_q   <= '0;
      ext_q   <= '0;
      a1_q    <= '0;
      a2_q    <= '0;
      a3_q    <= '0;
      tnew_q  <= '0;
      wen_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (en) begin
      instr_q <= instr_in;
      pc_q    <= pc_in;
      pc8_q   <= pc_in + PC_STEP;
      rd1_q   <= rd1_in;
      rd2_q   <= rd2_in;
      ext_q   <= ext_in;
      a1_q    <= a1_in;
      a2_q    <= a2_in;
      a3_q    <= nxt_dest;
      tnew_q  <= nxt_tnew;
      wen_q   <= nxt_wen;
      valid_q <= 1'b1;
    end
  end

  assign instr = instr_q;
  assign pc    = pc_q;
  assign pc8   = pc8_q;
  assign rd1   = rd1_q;
  assign rd2   = rd2_q;
  assign ext   = ext_q;
  assign a1    = a1_q;
  assign a2    = a2_q;
  assign a3    = a3_q;
  assign tnew  = tnew_q;
  assign wen   = wen_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one decode-mode and one downstream-mode
// instance share the same stimulus; expected values are hand-computed.
module tb_pipe_stage_reg;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int TW   = 2;

  logic            clk = 1'b0;
  logic            reset, en, flush, wen_in;
  logic [XLEN-1:0] instr_in, pc_in, rd1_in, rd2_in, ext_in;
  logic [RW-1:0]   a1_in, a2_in, a3_in;
  logic [TW-1:0]   tnew_in;

  logic [XLEN-1:0] instr0, pc0, pc8_0, rd1_0, rd2_0, ext0;
  logic [RW-1:0]   a1_0, a2_0, a3_0;
  logic [TW-1:0]   tnew0;
  logic            wen0, valid0;

  logic [XLEN-1:0] instr1, pc1, pc8_1, rd1_1, rd2_1, ext1;
  logic [RW-1:0]   a1_1, a2_1, a3_1;
  logic [TW-1:0]   tnew1;
  logic            wen1, valid1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.XLEN(XLEN), .RW(RW), .TW(TW), .MODE(0)) u_dut_dec (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .instr_in(instr_in), .pc_in(pc_in), .rd1_in(rd1_in), .rd2_in(rd2_in),
    .ext_in(ext_in), .a1_in(a1_in), .a2_in(a2_in), .a3_in(a3_in),
    .tnew_in(tnew_in), .wen_in(wen_in),
    .instr(instr0), .pc(pc0), .pc8(pc8_0), .rd1(rd1_0), .rd2(rd2_0), .ext(ext0),
    .a1(a1_0), .a2(a2_0), .a3(a3_0), .tnew(tnew0), .wen(wen0), .valid(valid0)
  );

  pipe_stage_reg #(.XLEN(XLEN), .RW(RW), .TW(TW), .MODE(1)) u_dut_ds (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .instr_in(instr_in), .pc_in(pc_in), .rd1_in(rd1_in), .rd2_in(rd2_in),
    .ext_in(ext_in), .a1_in(a1_in), .a2_in(a2_in), .a3_in(a3_in),
    .tnew_in(tnew_in), .wen_in(wen_in),
    .instr(instr1), .pc(pc1), .pc8(pc8_1), .rd1(rd1_1), .rd2(rd2_1), .ext(ext1),
    .a1(a1_1), .a2(a2_1), .a3(a3_1), .tnew(tnew1), .wen(wen1), .valid(valid1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pcv);
    instr_in = ins;
    pc_in    = pcv;
    rd1_in   = ins ^ 32'h1111_1111;
    rd2_in   = ins ^ 32'h2222_2222;
    ext_in   = {16'h0, ins[15:0]};
    a1_in    = ins[25:21];
    a2_in    = ins[20:16];
  endtask

  task automatic check_bubble0(input string tag);
    check({tag, ".valid"}, 32'(valid0), 32'd0);
    check({tag, ".wen"},   32'(wen0),   32'd0);
    check({tag, ".instr"}, instr0,      32'd0);
    check({tag, ".pc8"},   pc8_0,       32'd8);
    check({tag, ".a3"},    32'(a3_0),   32'd0);
    check({tag, ".tnew"},  32'(tnew0),  32'd0);
  endtask

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic [1:0]  tnew;
    logic [4:0]  a3;
    logic        wen;
  } dec_vec_t;

  dec_vec_t dec_tab[9];

  initial begin
    dec_tab[0] = '{"ori",     32'h3443_0005, 2'd1, 5'd3,  1'b1};
    dec_tab[1] = '{"subu",    32'h0022_2023, 2'd1, 5'd4,  1'b1};
    dec_tab[2] = '{"addu",    32'h0022_1821, 2'd1, 5'd3,  1'b1};
    dec_tab[3] = '{"lui_r0",  32'h3C00_1234, 2'd1, 5'd0,  1'b0};
    dec_tab[4] = '{"beq",     32'h1022_0003, 2'd0, 5'd0,  1'b0};
    dec_tab[5] = '{"sw",      32'hAC22_0004, 2'd0, 5'd0,  1'b0};
    dec_tab[6] = '{"jr",      32'h03E0_0008, 2'd0, 5'd0,  1'b0};
    dec_tab[7] = '{"op3f",    32'hFC00_0000, 2'd0, 5'd0,  1'b0};
    dec_tab[8] = '{"nop",     32'h0000_0000, 2'd0, 5'd0,  1'b0};

    reset = 1'b0; en = 1'b0; flush = 1'b0;
    tnew_in = '0; a3_in = '0; wen_in = 1'b0;
    drive(32'h0, 32'h0);

    // Power-up state, before any reset.
    #1;
    check("pwrup.valid", 32'(valid0), 32'd0);
    check("pwrup.pc8",   pc8_0,       32'd8);
    check("pwrup.wen",   32'(wen1),   32'd0);

    reset = 1'b1;
    step();
    check_bubble0("reset");
    reset = 1'b0;

    // lw r2, 4(r1)
    en = 1'b1;
    drive(32'h8C22_0004, 32'h0000_1000);
    tnew_in = 2'd3; a3_in = 5'd7; wen_in = 1'b1;
    step();
    check("lw.tnew",  32'(tnew0),  32'd2);
    check("lw.a3",    32'(a3_0),   32'd2);
    check("lw.wen",   32'(wen0),   32'd1);
    check("lw.valid", 32'(valid0), 32'd1);
    check("lw.instr", instr0,      32'h8C22_0004);
    check("lw.pc8",   pc8_0,       32'h0000_1008);
    check("lw.rd1",   rd1_0,       32'h9D33_1115);
    check("lw.rd2",   rd2_0,       32'hAE00_2226);
    check("lw.ext",   ext0,        32'h0000_0004);
    check("lw.a1",    32'(a1_0),   32'd1);
    check("lw.a2",    32'(a2_0),   32'd2);
    check("ds3.tnew", 32'(tnew1),  32'd2);
    check("ds3.a3",   32'(a3_1),   32'd7);
    check("ds3.wen",  32'(wen1),   32'd1);

    // jal 0x40 from pc 0x3000
    drive(32'h0C00_0010, 32'h0000_3000);
    tnew_in = 2'd0; a3_in = 5'd0; wen_in = 1'b1;
    step();
    check("jal.tnew", 32'(tnew0), 32'd0);
    check("jal.a3",   32'(a3_0),  32'd31);
    check("jal.wen",  32'(wen0),  32'd1);
    check("jal.pc8",  pc8_0,      32'h0000_3008);
    check("ds0.tnew", 32'(tnew1), 32'd0);
    check("ds0.wen",  32'(wen1),  32'd0);
    check("ds0.a3",   32'(a3_1),  32'd0);

    // Downstream countdown and write-flag passthrough, plus pc8 wrap.
    drive(32'h0000_0000, 32'hFFFF_FFFC);
    tnew_in = 2'd1; a3_in = 5'd9; wen_in = 1'b1;
    step();
    check("ds1.tnew", 32'(tnew1), 32'd0);
    check("ds1.wen",  32'(wen1),  32'd1);
    check("ds.pc8wrap", pc8_1,    32'h0000_0004);
    tnew_in = 2'd2; a3_in = 5'd5; wen_in = 1'b0;
    step();
    check("ds2.tnew", 32'(tnew1), 32'd1);
    check("ds2.a3",   32'(a3_1),  32'd5);
    check("ds2.wen",  32'(wen1),  32'd0);
    check("ds2.valid", 32'(valid1), 32'd1);

    // Decode table sweep.
    for (int i = 0; i < 9; i++) begin
      drive(dec_tab[i].ins, 32'h0000_2000 + 32'(i * 4));
      step();
      check({dec_tab[i].name, ".wen"},   32'(wen0),   32'(dec_tab[i].wen));
      check({dec_tab[i].name, ".a3"},    32'(a3_0),   32'(dec_tab[i].a3));
      check({dec_tab[i].name, ".valid"}, 32'(valid0), 32'd1);
      if (dec_tab[i].a3 != 5'd0 || dec_tab[i].tnew == 2'd0)
        check({dec_tab[i].name, ".tnew"}, 32'(tnew0), 32'(dec_tab[i].tnew));
    end

    // Load addu, stall three cycles with changing inputs, then flush while stalled.
    drive(32'h0022_1821, 32'h0000_4000);
    step();
    check("addu.tnew", 32'(tnew0), 32'd1);
    check("addu.a3",   32'(a3_0),  32'd3);
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(32'h8C22_0004 + 32'(c), 32'h0000_5000 + 32'(c * 4));
      step();
      check("hold.instr", instr0,      32'h0022_1821);
      check("hold.pc8",   pc8_0,       32'h0000_4008);
      check("hold.a3",    32'(a3_0),   32'd3);
      check("hold.tnew",  32'(tnew0),  32'd1);
      check("hold.valid", 32'(valid0), 32'd1);
    end
    flush = 1'b1;
    step();
    check_bubble0("stallflush");
    flush = 1'b0;

    // Flush with en=1 still inserts a bubble.
    en = 1'b1;
    drive(32'h8C22_0004, 32'h0000_6000);
    step();
    check("pre.valid", 32'(valid0), 32'd1);
    flush = 1'b1;
    step();
    check_bubble0("flushen");
    flush = 1'b0;

    // Reset during a stall discards the held instruction.
    step();
    en = 1'b0;
    step();
    check("stall.valid", 32'(valid0), 32'd1);
    reset = 1'b1;
    step();
    check_bubble0("rststall");

    // Reset, flush and enable together; then a normal load.
    en = 1'b1; flush = 1'b1;
    step();
    check_bubble0("rstall");
    reset = 1'b0; flush = 1'b0;
    drive(32'h3443_0005, 32'h0000_7000);
    step();
    check("post.instr", instr0,      32'h3443_0005);
    check("post.valid", 32'(valid0), 32'd1);
    check("post.a3",    32'(a3_0),   32'd3);
    check("post.pc8",   pc8_0,       32'h0000_7008);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter XLEN, default 32, datapath width of instr/pc/operand/ext fields.
REQ-002 Parameter RW, default 5, register-address width.
REQ-003 Parameter TW, default 2, T_new field width.
REQ-004 Parameter MODE, default 0; 0 = decode stage (T_new/dest derived from instr_in), 1 = downstream stage (T_new/dest taken from inputs).
REQ-005 One clock and a synchronous, active-high reset, stated exactly as follows.
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
REQ-006 Control ports:
- en  in  1  load enable; 0 = stall/hold.
- flush  in  1  insert bubble.
REQ-007 Payload inputs:
- instr_in  in  XLEN  instruction.
- pc_in  in  XLEN  PC of the instruction.
- rd1_in, rd2_in  in  XLEN  operand values.
- ext_in  in  XLEN  extended immediate.
- a1_in, a2_in, a3_in  in  RW  rs/rt/dest addresses; a3_in used only when MODE=1.
- tnew_in  in  TW  T_new from previous stage; MODE=1 only.
- wen_in  in  1  register-write flag from previous stage; MODE=1 only.
REQ-008 Outputs:
- instr, pc, pc8, rd1, rd2, ext  out  XLEN  registered payload; pc8 = pc + 8, modulo 2^XLEN.
- a1, a2, a3  out  RW  registered addresses.
- tnew  out  TW  cycles until the result is available.
- wen  out  1  stage holds a real register write.
- valid  out  1  stage holds a non-bubble instruction.

Function
REQ-009 Rising-edge priority: reset, then flush, then hold (en=0), then load (en=1).
REQ-010 Bubble state: every output is 0 (pc8 = 8), wen=0, valid=0.
REQ-011 flush=1 loads the bubble regardless of en; stall+flush yields a bubble.
REQ-012 en=0 with flush=0 holds every output unchanged, for any number of cycles.
REQ-013 On load: instr, pc, rd1, rd2, ext, a1 and a2 capture their inputs; valid=1; latency is one cycle.
REQ-014 MODE=0 decode table (opcode instr_in[31:26], funct [5:0]):
- ori 001101: tnew 1, dest rt.
- lui 001111: tnew 1, dest rt.
- lw 100011: tnew 2, dest rt.
- jal 000011: tnew 0, dest 31.
- SPECIAL 000000 with addu 100001 or subu 100011: tnew 1, dest rd.
- All others (beq, sw, j, jr, nop, undefined): wen=0, tnew=0, a3=0.
REQ-015 MODE=1 load: tnew = tnew_in-1 saturating at 0 (tnew_in=0 gives 0); a3 = a3_in; wen = wen_in.
REQ-016 In both modes, a destination of 0 forces wen=0 and a3=0 in the same load.
REQ-017 Saturation applies at TW width; tnew never wraps to all-ones.
REQ-018 Outputs come from registers only; no combinational input-to-output path.

Reset
REQ-019 reset=1 at a rising edge loads the bubble state (REQ-010), overriding en and flush.
REQ-020 Reset asserted mid-stall discards the held instruction.
REQ-021 Registers power up to the bubble state before the first reset.

Structure
REQ-022 Opcode/funct constants, the MODE encoding and tnew values belong in shared package pipe_pkg.
REQ-023 The MODE=0 decoder is sub-module tnew_decode: combinational, instr in, {tnew, dest, wen} out.
REQ-024 MODE is resolved at elaboration time (generate); the decoder is not instantiated when MODE=1.

Verification
REQ-025 MODE=0, en=1, instr=0x8C220004 (lw) -> next cycle tnew=2, a3=2, wen=1, valid=1.
REQ-026 MODE=0, instr=0x0C000010 (jal), pc_in=0x3000 -> tnew=0, a3=31, wen=1, pc8=0x3008.
REQ-027 MODE=1, tnew_in=0 and wen_in=1, a3_in=0 -> tnew=0 (no wrap), wen=0, a3=0.
REQ-028 Load addu, then en=0 for 3 cycles with new inputs -> outputs unchanged; then flush=1 with en=0 -> bubble, valid=0.
REQ-029 en=1, flush=1, reset=1 in the same cycle -> bubble; after reset deasserts, the next en=1 load captures normally.
REQ-030 MODE=0, beq/sw/jr/unknown opcode 0x3F -> wen=0, tnew=0, a3=0, valid=1.
